// File: rtl/crossing_controller_param.sv
// crossing_controller_param
//   Pedestrian/cyclist crossing controller with NREQ latched request channels,
//   a per-phase down-counting timer, a minimum traffic-green guarantee, a
//   flashing clearance phase and a flashing-amber night mode.
// Ports
//   clock      in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   start      in   [NREQ] request buttons, sampled each rising edge
//   night      in   night-mode request (level)
//   lightseq   out  [6] {traffic R,A,G, cross R, 0, cross G}
//   wait_lamp  out  [NREQ] registered-request lamps
//   busy       out  high outside GREEN and NIGHT
module crossing_controller_param #(
  parameter int NREQ      = 2,
  parameter int CNT_W     = 8,
  parameter int MIN_GREEN = 20,
  parameter int AMBER_T   = 3,
  parameter int CLEAR_T   = 2,
  parameter int CROSS_T   = 10,
  parameter int FLASH_T   = 6,
  parameter int FLASH_DIV = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NREQ-1:0] start,
  input  logic            night,
  output logic [5:0]      lightseq,
  output logic [NREQ-1:0] wait_lamp,
  output logic            busy
);

  localparam logic [2:0] S_GREEN   = 3'd0;
  localparam logic [2:0] S_AMBER   = 3'd1;
  localparam logic [2:0] S_ALL_RED = 3'd2;
  localparam logic [2:0] S_CROSS   = 3'd3;
  localparam logic [2:0] S_CFLASH  = 3'd4;
  localparam logic [2:0] S_NIGHT   = 3'd5;

  localparam int FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

  localparam logic [CNT_W-1:0] L_GREEN = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] L_AMBER = CNT_W'(AMBER_T - 1);
  localparam logic [CNT_W-1:0] L_CLEAR = CNT_W'(CLEAR_T - 1);
  localparam logic [CNT_W-1:0] L_CROSS = CNT_W'(CROSS_T - 1);
  localparam logic [CNT_W-1:0] L_FLASH = CNT_W'(FLASH_T - 1);
  localparam logic [FW-1:0]    L_FDIV  = FW'(FLASH_DIV - 1);

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_timer;
  logic [NREQ-1:0]  r_pend;
  logic             r_flash;
  logic [FW-1:0]    r_fcnt;

  logic [2:0]       w_nstate;
  logic [CNT_W-1:0] w_ntimer;
  logic [NREQ-1:0]  w_npend;
  logic             w_tz;
  logic             w_flashing;
  logic             w_enter_fl;

  assign w_tz       = (r_timer == '0);
  assign w_flashing = (r_state == S_CFLASH) || (r_state == S_NIGHT);
  assign w_enter_fl = (w_nstate != r_state) &&
                      ((w_nstate == S_CFLASH) || (w_nstate == S_NIGHT));

  always_comb begin
    w_nstate = r_state;
    w_ntimer = w_tz ? '0 : r_timer - 1'b1;
    w_npend  = r_pend;
    case (r_state)
      S_GREEN: begin
        w_npend = r_pend | start;
        if (night) begin
          w_nstate = S_NIGHT;
        end else if (w_tz && (|r_pend)) begin
          w_nstate = S_AMBER;
          w_ntimer = L_AMBER;
        end
      end
      S_AMBER: begin
        w_npend = r_pend | start;
        if (w_tz) begin
          w_nstate = S_ALL_RED;
          w_ntimer = L_CLEAR;
        end
      end
      S_ALL_RED: begin
        w_npend = r_pend | start;
        if (w_tz) begin
          w_nstate = S_CROSS;
          w_ntimer = L_CROSS;
          // the crossing about to open serves every outstanding request
          w_npend  = '0;
        end
      end
      S_CROSS: begin
        if (w_tz) begin
          w_nstate = S_CFLASH;
          w_ntimer = L_FLASH;
        end
      end
      S_CFLASH: begin
        w_npend = r_pend | start;
        if (w_tz) begin
          w_nstate = S_GREEN;
          w_ntimer = L_GREEN;
        end
      end
      S_NIGHT: begin
        w_npend = '0;
        if (!night) begin
          w_nstate = S_GREEN;
          w_ntimer = L_GREEN;
        end
      end
      default: begin
        w_nstate = S_GREEN;
        w_ntimer = L_GREEN;
      end
    endcase
    // requests are dropped on the way into night mode
    if (w_nstate == S_NIGHT) w_npend = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_GREEN;
      r_timer <= L_GREEN;
      r_pend  <= '0;
      r_flash <= 1'b1;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_nstate;
      r_timer <= w_ntimer;
      r_pend  <= w_npend;
      if (w_enter_fl) begin
        r_flash <= 1'b1;
        r_fcnt  <= '0;
      end else if (w_flashing) begin
        if (r_fcnt == L_FDIV) begin
          r_flash <= ~r_flash;
          r_fcnt  <= '0;
        end else begin
          r_fcnt  <= r_fcnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    case (r_state)
      S_GREEN:   lightseq = 6'b001100;
      S_AMBER:   lightseq = 6'b010100;
      S_ALL_RED: lightseq = 6'b100100;
      S_CROSS:   lightseq = 6'b100001;
      S_CFLASH:  lightseq = {1'b0, r_flash, 3'b000, r_flash};
      S_NIGHT:   lightseq = {1'b0, r_flash, 4'b0000};
      default:   lightseq = 6'b100100;
    endcase
  end

  assign wait_lamp = r_pend;
  assign busy      = (r_state != S_GREEN) && (r_state != S_NIGHT);

endmodule

// File: tb/tb_crossing_controller_param.sv
module tb_crossing_controller_param;
  localparam int NREQ      = 2;
  localparam int MIN_GREEN = 20;
  localparam int AMBER_T   = 3;
  localparam int CLEAR_T   = 2;
  localparam int CROSS_T   = 10;
  localparam int FLASH_T   = 6;
  localparam int FLASH_DIV = 2;

  // model phases
  localparam int P_GREEN = 0, P_AMBER = 1, P_ALLRED = 2, P_CROSS = 3, P_CFL = 4, P_NIGHT = 5;

  logic            clock = 1'b0;
  logic            reset;
  logic [NREQ-1:0] start;
  logic            night;
  logic [5:0]      lightseq;
  logic [NREQ-1:0] wait_lamp;
  logic            busy;

  int checks = 0;
  int errors = 0;

  // reference model: phase, cycles spent in phase, pending set
  int              m_ph;
  int              m_el;
  logic [NREQ-1:0] m_pend;

  crossing_controller_param #(
    .NREQ(NREQ), .CNT_W(8), .MIN_GREEN(MIN_GREEN), .AMBER_T(AMBER_T),
    .CLEAR_T(CLEAR_T), .CROSS_T(CROSS_T), .FLASH_T(FLASH_T), .FLASH_DIV(FLASH_DIV)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .night(night),
    .lightseq(lightseq), .wait_lamp(wait_lamp), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] exp_light(input int ph, input int el);
    logic f;
    f = ((el / FLASH_DIV) % 2) == 0;
    case (ph)
      P_GREEN:  return 6'b001100;
      P_AMBER:  return 6'b010100;
      P_ALLRED: return 6'b100100;
      P_CROSS:  return 6'b100001;
      P_CFL:    return {1'b0, f, 3'b000, f};
      default:  return {1'b0, f, 4'b0000};
    endcase
  endfunction

  task automatic model_reset();
    m_ph = P_GREEN; m_el = 0; m_pend = '0;
  endtask

  // advance the model by one clock using the inputs present at the edge
  task automatic model_step(input logic [NREQ-1:0] s, input logic n);
    int nph;
    nph = m_ph;
    case (m_ph)
      P_GREEN:  if (n) nph = P_NIGHT;
                else if (m_el >= MIN_GREEN - 1 && m_pend != '0) nph = P_AMBER;
      P_AMBER:  if (m_el == AMBER_T - 1) nph = P_ALLRED;
      P_ALLRED: if (m_el == CLEAR_T - 1) nph = P_CROSS;
      P_CROSS:  if (m_el == CROSS_T - 1) nph = P_CFL;
      P_CFL:    if (m_el == FLASH_T - 1) nph = P_GREEN;
      default:  if (!n) nph = P_GREEN;
    endcase
    if (nph == P_NIGHT || m_ph == P_NIGHT || (nph == P_CROSS && m_ph != P_CROSS)) m_pend = '0;
    else if (m_ph != P_CROSS) m_pend = m_pend | s;
    m_el = (nph != m_ph) ? 0 : m_el + 1;
    m_ph = nph;
  endtask

  task automatic compare_all();
    chk("lightseq", 32'(lightseq), 32'(exp_light(m_ph, m_el)));
    chk("wait_lamp", 32'(wait_lamp), 32'(m_pend));
    chk("busy", 32'(busy), 32'(m_ph != P_GREEN && m_ph != P_NIGHT));
  endtask

  task automatic step(input logic [NREQ-1:0] s, input logic n);
    start = s; night = n;
    @(posedge clock);
    model_step(s, n);
    #1;
    compare_all();
  endtask

  // idle until the model reaches a phase (and elapsed count), bounded
  task automatic run_to(input int ph, input int el, input int budget);
    int k;
    k = 0;
    while (!(m_ph == ph && m_el == el) && k < budget) begin
      step('0, 1'b0);
      k++;
    end
    checks++;
    if (!(m_ph == ph && m_el == el)) begin
      errors++;
      $display("FAIL run_to observed_phase=%0d required_phase=%0d", m_ph, ph);
    end
  endtask

  initial begin
    logic [NREQ-1:0] rs;
    logic            rn;
    reset = 1'b0; start = '0; night = 1'b0;
    model_reset();
    #3;
    chk("rst_light", 32'(lightseq), 32'h0C);
    chk("rst_wait", 32'(wait_lamp), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    #19 reset = 1'b1;

    // idle green for 100 cycles
    for (int i = 0; i < 100; i++) step('0, 1'b0);
    chk("idle_light", 32'(lightseq), 32'h0C);

    // a fresh request after reset: amber at cycle 20 from reset
    reset = 1'b0; #1; model_reset(); @(negedge clock); reset = 1'b1;
    for (int i = 0; i < 5; i++) step('0, 1'b0);
    step(2'b01, 1'b0);
    chk("req_lamp", 32'(wait_lamp), 32'h1);
    run_to(P_CROSS, 0, 40);
    chk("cross_lamp_clr", 32'(wait_lamp), 32'h0);

    // start[1] during crossing is ignored
    step(2'b10, 1'b0);
    chk("cross_ignore", 32'(wait_lamp), 32'h0);
    // start[0] during clearance flash is held for the next cycle
    run_to(P_CFL, 1, 20);
    step(2'b01, 1'b0);
    chk("cfl_hold", 32'(wait_lamp), 32'h1);
    run_to(P_AMBER, 0, 40);

    // simultaneous start on the edge into crossing is swallowed
    run_to(P_ALLRED, CLEAR_T - 1, 20);
    step(2'b11, 1'b0);
    chk("clr_beats_start", 32'(wait_lamp), 32'h0);
    run_to(P_GREEN, MIN_GREEN + 5, 60);
    chk("no_second_x", 32'(busy), 32'h0);

    // night overrides a pending request
    step(2'b01, 1'b0);
    step('0, 1'b1);
    chk("night_light", 32'(lightseq), 32'h10);
    chk("night_wait", 32'(wait_lamp), 32'h0);
    for (int i = 0; i < 8; i++) step(2'b11, 1'b1);
    step('0, 1'b0);
    chk("night_exit", 32'(lightseq), 32'h0C);

    // asynchronous reset in the middle of a crossing
    step(2'b01, 1'b0);
    run_to(P_CROSS, 4, 40);
    #3 reset = 1'b0;
    #1;
    model_reset();
    chk("arst_light", 32'(lightseq), 32'h0C);
    chk("arst_wait", 32'(wait_lamp), 32'h0);
    @(posedge clock); #1;
    chk("arst_hold", 32'(lightseq), 32'h0C);
    #3 reset = 1'b1;
    step(2'b10, 1'b0);
    run_to(P_AMBER, 0, 40);

    // randomized traffic
    rn = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < NREQ; b++) rs[b] = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 59) == 0) rn = ~rn;
      step(rs, rn);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
